// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch queue: control-flow opcodes and RV32 immediate decoders.
package fetch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // B-format offset, sign-extended to 32 bits (bit 0 always zero).
    function automatic logic [31:0] b_imm(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    // J-format offset, sign-extended to 32 bits (bit 0 always zero).
    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/instruction_fifo.sv
// DEPTH-entry synchronous FIFO with synchronous clear, occupancy count and combinational head.
module instruction_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != '0);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: issues icache requests, predicts the next PC from each response
// and buffers fetched instructions with their predictions until the decoder takes them.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 17,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_rst,
    input  logic [ADDR_WIDTH-1:0] new_pc,
    output logic [ADDR_WIDTH-1:0] branch_query_addr,
    input  logic                  branch_query_prediction,
    input  logic [ADDR_WIDTH-1:0] stack_top,
    output logic                  icache_fetch_en,
    output logic [ADDR_WIDTH-1:0] icache_fetch_addr,
    input  logic                  icache_out_en,
    input  logic                  icache_cinstruction,
    input  logic [31:0]           icache_instruction,
    input  logic                  decoder_ready,
    output logic                  instruction_en,
    output logic [31:0]           instruction,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] instruction_addr_prediction,
    output logic                  instruction_br_prediction,
    output logic [1:0]            o_dbg_state
);

    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [0:0] ST_ISSUE = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;

    typedef struct packed {
        logic [31:0]           instr;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] jalr_pred;
        logic                  br_pred;
    } entry_t;

    logic [0:0]            r_state;
    logic                  r_stale;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_req_pc;

    logic [CW-1:0]         w_count;
    logic                  w_not_empty;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    entry_t                w_head;
    entry_t                w_push_entry;
    logic [6:0]            w_opcode;
    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_next_pc;

    assign w_not_empty = (w_count != '0);
    // Only one request is ever outstanding, so in ISSUE the occupancy alone bounds the queue.
    // A redirect in the issue cycle suppresses the request rather than letting it go stale.
    assign w_issue = rst && !pc_rst && (r_state == ST_ISSUE) && (w_count < CW'(DEPTH));
    assign w_push  = (r_state == ST_WAIT) && icache_out_en && !r_stale && !pc_rst;
    assign w_pop   = w_not_empty && decoder_ready && !pc_rst;

    always_comb begin
        w_opcode  = icache_instruction[6:0];
        w_step    = icache_cinstruction ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4);
        w_next_pc = r_req_pc + w_step;
        case (w_opcode)
            OPC_BRANCH: begin
                if (branch_query_prediction) begin
                    w_next_pc = r_req_pc + ADDR_WIDTH'(b_imm(icache_instruction));
                end
            end
            OPC_JAL:  w_next_pc = r_req_pc + ADDR_WIDTH'(j_imm(icache_instruction));
            OPC_JALR: w_next_pc = stack_top;
            default:  w_next_pc = r_req_pc + w_step;
        endcase
    end

    assign w_push_entry = '{
        instr:     icache_instruction,
        pc:        r_req_pc,
        jalr_pred: stack_top,
        br_pred:   branch_query_prediction
    };

    instruction_fifo #(
        .WIDTH($bits(entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clear (pc_rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_ISSUE;
            r_stale    <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
        end else if (pc_rst) begin
            r_fetch_pc <= new_pc;
            // The in-flight response has not arrived yet: wait for it and throw it away.
            if ((r_state == ST_WAIT) && !icache_out_en) begin
                r_stale <= 1'b1;
            end else begin
                r_state <= ST_ISSUE;
                r_stale <= 1'b0;
            end
        end else if (r_state == ST_ISSUE) begin
            if (w_issue) begin
                r_state  <= ST_WAIT;
                r_req_pc <= r_fetch_pc;
            end
        end else if (icache_out_en) begin
            r_state <= ST_ISSUE;
            r_stale <= 1'b0;
            if (!r_stale) begin
                r_fetch_pc <= w_next_pc;
            end
        end
    end

    assign branch_query_addr           = r_req_pc;
    assign icache_fetch_en             = w_issue;
    assign icache_fetch_addr           = w_issue ? r_fetch_pc : '0;
    assign instruction_en              = w_not_empty;
    assign instruction                 = w_not_empty ? w_head.instr : '0;
    assign pc_out                      = w_not_empty ? w_head.pc : '0;
    assign instruction_addr_prediction = w_not_empty ? w_head.jalr_pred : '0;
    assign instruction_br_prediction   = w_not_empty && w_head.br_pred;
    assign o_dbg_state                 = {r_stale, r_state};

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: an icache responder with programmable latency feeds the
// DUT, a monitor logs issued requests and accepted instructions, and checks compare them.
module tb_fetch_queue;

    localparam int AW    = 17;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pc_rst = 1'b0;
    logic [AW-1:0] new_pc = '0;
    logic [AW-1:0] bqa;
    logic          bq_pred = 1'b0;
    logic [AW-1:0] stack_top = '0;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic          out_en = 1'b0;
    logic          cinstr = 1'b0;
    logic [31:0]   icache_instr = '0;
    logic          dec_ready = 1'b1;
    logic          instr_en;
    logic [31:0]   instr;
    logic [AW-1:0] pc_out;
    logic [AW-1:0] addr_pred;
    logic          br_pred;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .RESET_PC('0)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .pc_rst                     (pc_rst),
        .new_pc                     (new_pc),
        .branch_query_addr          (bqa),
        .branch_query_prediction    (bq_pred),
        .stack_top                  (stack_top),
        .icache_fetch_en            (fetch_en),
        .icache_fetch_addr          (fetch_addr),
        .icache_out_en              (out_en),
        .icache_cinstruction        (cinstr),
        .icache_instruction         (icache_instr),
        .decoder_ready              (dec_ready),
        .instruction_en             (instr_en),
        .instruction                (instr),
        .pc_out                     (pc_out),
        .instruction_addr_prediction(addr_pred),
        .instruction_br_prediction  (br_pred),
        .o_dbg_state                (dbg_state)
    );

    // icache model: answers each request after 'lat' cycles; unknown addresses return ADDI.
    logic [31:0]   imem [logic [AW-1:0]];
    bit            cmem [logic [AW-1:0]];
    int            lat = 1;
    int            resp_cnt = 0;
    logic [AW-1:0] resp_addr = '0;

    always @(negedge clk) begin
        if (rst && fetch_en) begin
            resp_cnt  = lat;
            resp_addr = fetch_addr;
        end
    end

    always @(posedge clk) begin
        #1;
        out_en       = 1'b0;
        cinstr       = 1'b0;
        icache_instr = '0;
        if (!rst) begin
            resp_cnt = 0;
        end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                out_en       = 1'b1;
                icache_instr = imem.exists(resp_addr) ? imem[resp_addr] : 32'h0000_0013;
                cinstr       = cmem.exists(resp_addr) ? cmem[resp_addr] : 1'b0;
            end
        end
    end

    // Monitor: logs requests and accepted instructions, counts head-valid cycles.
    int            cyc_n = 0;
    logic [AW-1:0] issue_q[$];
    int            issue_cyc[$];
    logic [AW-1:0] pop_pc_q[$];
    logic [31:0]   pop_instr_q[$];
    int            en_cycles = 0;
    logic [31:0]   exp_q[$];

    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (rst) begin
            if (fetch_en) begin
                issue_q.push_back(fetch_addr);
                issue_cyc.push_back(cyc_n);
            end
            if (instr_en && dec_ready && !pc_rst) begin
                pop_pc_q.push_back(pc_out);
                pop_instr_q.push_back(instr);
            end
            if (instr_en) en_cycles++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_issues(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_issue%0d", tag, i),
                  (issue_q.size() > i) ? 32'(issue_q[i]) : 32'hDEAD_BEEF, exp_q[i]);
        end
        exp_q.delete();
    endtask

    task automatic check_pops(input string tag);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_pop%0d", tag, i),
                  (pop_pc_q.size() > i) ? 32'(pop_pc_q[i]) : 32'hDEAD_BEEF, exp_q[i]);
        end
        exp_q.delete();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the caller at cycle C0 (no redirect) or C1 (redirect in C0), rst high.
    task automatic do_reset(input logic [AW-1:0] start, input bit redirect);
        cyc();
        rst    = 1'b0;
        pc_rst = 1'b0;
        imem.delete();
        cmem.delete();
        repeat (2) cyc();
        #2;
        check("rst_instr_en", instr_en, 0);
        check("rst_fetch_en", fetch_en, 0);
        check("rst_fetch_addr", fetch_addr, 0);
        check("rst_bq_addr", bqa, 0);
        check("rst_pc_out", pc_out, 0);
        check("rst_dbg", dbg_state, 0);
        issue_q.delete();
        issue_cyc.delete();
        pop_pc_q.delete();
        pop_instr_q.delete();
        en_cycles = 0;
        cyc();
        rst = 1'b1;
        if (redirect) begin
            pc_rst = 1'b1;
            new_pc = start;
            cyc();
            pc_rst = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Sequential ADDI stream from reset
        lat = 1; dec_ready = 1'b1; bq_pred = 1'b0; stack_top = '0;
        do_reset('0, 1'b0);
        #2;
        check("t1_first_en", fetch_en, 1);
        check("t1_first_addr", fetch_addr, 0);
        repeat (7) cyc();
        exp_q = '{32'h0, 32'h4, 32'h8};
        check_issues("t1");
        exp_q = '{32'h0, 32'h4, 32'h8};
        check_pops("t1");
        check("t1_interval", (issue_cyc.size() > 1) ? issue_cyc[1] - issue_cyc[0] : -1, 2);
        check("t1_en_cycles", en_cycles, 3);
        check("t1_instr", (pop_instr_q.size() > 0) ? pop_instr_q[0] : 32'hDEAD_BEEF, 32'h13);

        // BEQ -8 at 0x10, predicted taken
        bq_pred = 1'b1;
        do_reset(17'h10, 1'b1);
        imem[17'h10] = 32'hFE00_0CE3;
        cyc(); cyc(); #2;
        check("t2t_fetch_addr", fetch_addr, 17'h08);
        check("t2t_pc_out", pc_out, 17'h10);
        check("t2t_br_pred", br_pred, 1);
        check("t2t_instr", instr, 32'hFE00_0CE3);

        // Same branch, predicted not taken
        bq_pred = 1'b0;
        do_reset(17'h10, 1'b1);
        imem[17'h10] = 32'hFE00_0CE3;
        cyc(); cyc(); #2;
        check("t2n_fetch_addr", fetch_addr, 17'h14);
        check("t2n_br_pred", br_pred, 0);

        // Compressed instruction advances by 2
        do_reset(17'h20, 1'b1);
        imem[17'h20] = 32'h0000_0001;
        cmem[17'h20] = 1'b1;
        cyc(); cyc(); #2;
        check("t3c_fetch_en", fetch_en, 1);
        check("t3c_fetch_addr", fetch_addr, 17'h22);
        check("t3c_pc_out", pc_out, 17'h20);

        // JALR follows the return-stack top
        stack_top = 17'h1234;
        do_reset(17'h30, 1'b1);
        imem[17'h30] = 32'h0000_8067;
        cyc(); cyc(); #2;
        check("t3j_fetch_addr", fetch_addr, 17'h1234);
        check("t3j_addr_pred", addr_pred, 17'h1234);
        check("t3j_instr", instr, 32'h0000_8067);
        stack_top = '0;

        // Decoder stalled: queue fills to DEPTH, one pop admits exactly one request
        dec_ready = 1'b0;
        do_reset('0, 1'b0);
        repeat (20) cyc();
        check("t4_n_issue", issue_q.size(), 4);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        check_issues("t4");
        #2;
        check("t4_en", instr_en, 1);
        check("t4_head", pc_out, 0);
        check("t4_dbg", dbg_state, 2'b00);
        check("t4_no_req", fetch_en, 0);
        cyc();
        dec_ready = 1'b1;
        cyc();
        dec_ready = 1'b0;
        repeat (10) cyc();
        check("t4_n_issue_after", issue_q.size(), 5);
        check("t4_5th_addr", (issue_q.size() > 4) ? 32'(issue_q[4]) : 32'hDEAD_BEEF, 32'h10);
        check("t4_n_pop", pop_pc_q.size(), 1);
        #2;
        check("t4_head_after", pc_out, 17'h4);

        // Redirect while a slow response is in flight: stale data is dropped
        lat = 3; dec_ready = 1'b1;
        do_reset('0, 1'b0);
        cyc();
        pc_rst = 1'b1;
        new_pc = 17'h100;
        cyc();
        pc_rst = 1'b0;
        #2;
        check("t5_dbg_stale", dbg_state, 2'b11);
        check("t5_no_req", fetch_en, 0);
        repeat (12) cyc();
        exp_q = '{32'h0, 32'h100, 32'h104};
        check_issues("t5");
        check("t5_gap", (issue_cyc.size() > 1) ? issue_cyc[1] - issue_cyc[0] : -1, 4);
        exp_q = '{32'h100, 32'h104};
        check_pops("t5");
        check("t5_en_cycles", en_cycles, 2);

        // Redirect coincident with a response and a pop while two entries are queued
        lat = 1; dec_ready = 1'b0;
        do_reset('0, 1'b0);
        repeat (5) cyc();
        dec_ready = 1'b1;
        pc_rst    = 1'b1;
        new_pc    = 17'h200;
        #2;
        check("t6_en_before", instr_en, 1);
        check("t6_head_before", pc_out, 0);
        check("t6_dbg_wait", dbg_state, 2'b01);
        cyc();
        pc_rst = 1'b0;
        #2;
        check("t6_en_after", instr_en, 0);
        check("t6_req_en", fetch_en, 1);
        check("t6_req_addr", fetch_addr, 17'h200);
        repeat (3) cyc();
        check("t6_n_pop", pop_pc_q.size(), 1);
        exp_q = '{32'h200};
        check_pops("t6");

        // JAL +8 at the top of the address space wraps to 0x4
        do_reset(17'h1FFFC, 1'b1);
        imem[17'h1FFFC] = 32'h0080_006F;
        cyc(); cyc(); #2;
        check("t7_fetch_addr", fetch_addr, 17'h00004);
        check("t7_pc_out", pc_out, 17'h1FFFC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
